// File: rtl/act_skew_feeder_if.sv
// Activation feeder bus: upstream valid/ready vector handshake plus the skewed
// array-side outputs and status.
interface act_skew_feeder_if #(
  parameter int unsigned SYS_ARR_SIZE = 8,
  parameter int unsigned ACT_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 16
);
  logic                              in_valid;
  logic                              in_ready;
  logic                              in_last;
  logic [SYS_ARR_SIZE*ACT_WIDTH-1:0] in_data;
  logic [SYS_ARR_SIZE*ACT_WIDTH-1:0] act_data_out;
  logic [SYS_ARR_SIZE-1:0]           act_valid_out;
  logic                              busy;
  logic                              done;
  logic [CNT_WIDTH-1:0]              vec_count;

  modport master (
    output in_valid, in_last, in_data,
    input  in_ready, act_data_out, act_valid_out, busy, done, vec_count
  );

  modport slave (
    input  in_valid, in_last, in_data,
    output in_ready, act_data_out, act_valid_out, busy, done, vec_count
  );
endinterface

// File: rtl/act_skew_feeder.sv
// Systolic-array activation feeder: accepts one vector per cycle and delays lane i
// by i extra cycles, then flushes the skew pipe and pulses done after the last vector.
module act_skew_feeder #(
  parameter int unsigned SYS_ARR_SIZE = 8,
  parameter int unsigned ACT_WIDTH    = 16,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input logic              clk,
  input logic              reset,
  act_skew_feeder_if.slave bus
);

  localparam int unsigned CntW = (SYS_ARR_SIZE > 1) ? $clog2(SYS_ARR_SIZE) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SYS_ARR_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StStream, StFlush} state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] vec_count_q, vec_count_d;

  logic in_ready, busy, done, accept;

  logic [SYS_ARR_SIZE*ACT_WIDTH-1:0] act_data;
  logic [SYS_ARR_SIZE-1:0]           act_valid;

  assign accept = bus.in_valid & in_ready;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) state_d = bus.in_last ? StFlush : StStream;
      end
      StStream: begin
        if (accept && bus.in_last) state_d = StFlush;
      end
      StFlush: begin
        if (cnt_q == '0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = (state_q != StFlush);
    busy     = (state_q != StIdle);
    done     = (state_q == StFlush) && (cnt_q == '0);
  end

  // Flush countdown and stream vector count; no accept can happen during flush.
  always_comb begin
    cnt_d       = cnt_q;
    vec_count_d = vec_count_q;
    if (accept) begin
      vec_count_d = (state_q == StIdle) ? CNT_WIDTH'(1) : vec_count_q + CNT_WIDTH'(1);
      if (bus.in_last) cnt_d = CntLoad;
    end else if (state_q == StFlush && cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q       <= '0;
      vec_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      vec_count_q <= vec_count_d;
    end
  end

  // Lane i is a shift register of depth i+1 that advances every clock regardless of input.
  for (genvar gi = 0; gi < SYS_ARR_SIZE; gi++) begin : g_lane
    logic [gi:0][ACT_WIDTH-1:0] dat_q, dat_d;
    logic [gi:0]                vld_q, vld_d;

    always_comb begin
      dat_d[0] = accept ? bus.in_data[gi*ACT_WIDTH +: ACT_WIDTH] : '0;
      vld_d[0] = accept;
      for (int s = 1; s <= gi; s++) begin
        dat_d[s] = dat_q[s-1];
        vld_d[s] = vld_q[s-1];
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        dat_q <= '0;
        vld_q <= '0;
      end else begin
        dat_q <= dat_d;
        vld_q <= vld_d;
      end
    end

    assign act_data[gi*ACT_WIDTH +: ACT_WIDTH] = dat_q[gi];
    assign act_valid[gi]                       = vld_q[gi];
  end

  assign bus.in_ready      = in_ready;
  assign bus.busy          = busy;
  assign bus.done          = done;
  assign bus.vec_count     = vec_count_q;
  assign bus.act_data_out  = act_data;
  assign bus.act_valid_out = act_valid;

endmodule
